alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_mc.sv | 117 +++++++++++
 tb/tb_alu_mc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the multi-cycle ALU and its bench.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SLTU = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH steps in total,
// the first step taken on the start cycle so the product is ready WIDTH cycles later.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;

    // {hi, lo} step: add the multiplicand to hi when lo[0] is set, then shift the pair right.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur[2*WIDTH-1:WIDTH]} + (cur[0] ? {1'b0, m} : '0);
        return {sum, cur[WIDTH-1:1]};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: counter and accumulator are cleared on reset so an aborted multiply leaves nothing stale.
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            acc   <= step({{WIDTH{1'b0}}, b}, a);
            mcand <= a;
        end else if (busy) begin
            if (cnt != '0) begin
                acc <= step(acc, mcand);
                cnt <= cnt - CW'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL, valid/ready on both sides,
// one operation in flight at a time with registered result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    alu_state_e         state_q, state_d;
    logic               accept, is_mul, mul_start, mul_done, load;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     add_full, sub_full;
    logic [WIDTH-1:0]   res_d;
    logic               c_d, v_d;

    assign is_mul = (alu_op_e'(op) == OP_MUL);
    assign accept = in_valid && (state_q == ST_IDLE);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                mul_start = is_mul;
                state_d   = is_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // The borrow of a-b lands in the extra top bit, which equals a<b unsigned.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        if (state_q == ST_MUL) begin
            res_d = product[WIDTH-1:0];
            v_d   = |product[2*WIDTH-1:WIDTH];
        end else begin
            case (alu_op_e'(op))
                OP_ADD: begin
                    res_d = add_full[WIDTH-1:0];
                    c_d   = add_full[WIDTH];
                    v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    res_d = sub_full[WIDTH-1:0];
                    c_d   = sub_full[WIDTH];
                    v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
                end
                OP_AND:  res_d = a & b;
                OP_OR:   res_d = a | b;
                OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
                OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                default: res_d = '0;
            endcase
        end
    end

    assign load = (accept && !is_mul) || ((state_q == ST_MUL) && mul_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            z <= 1'b0;
            n <= 1'b0;
            c <= 1'b0;
            v <= 1'b0;
        end else if (load) begin
            r <= res_d;
            z <= (res_d == '0);
            n <= res_d[WIDTH-1];
            c <= c_d;
            v <= v_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_mc.sv
// Randomized scoreboard bench for alu_mc: driver pushes expected results, monitor pops and compares.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] r;
    logic         z, n, c, v;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .z(z), .n(n), .c(c), .v(v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         z, n, c, v;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   hold_low   = 1'b0;
    bit   force_high = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = hold_low ? 1'b0 : (force_high ? 1'b1 : ($urandom_range(0, 2) != 0));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input int at);
        exp_t           e;
        longint         sx = $signed(x);
        longint         sy = $signed(y);
        longint         sres;
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned full;
        e.c = 1'b0; e.v = 1'b0; e.r = '0;
        e.lat = 1; e.acc_cyc = at;
        case (alu_op_e'(o))
            OP_ADD: begin
                full = ux + uy; e.r = full[W-1:0]; e.c = full[W];
                sres = sx + sy; e.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            OP_SUB: begin
                full = ux - uy; e.r = full[W-1:0]; e.c = (ux < uy);
                sres = sx - sy; e.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            OP_AND:  e.r = x & y;
            OP_OR:   e.r = x | y;
            OP_MUL: begin
                full = ux * uy; e.r = full[W-1:0]; e.v = (full[63:32] != 0); e.lat = W + 1;
            end
            OP_SLTU: e.r = (ux < uy) ? 1 : 0;
            OP_SLT:  e.r = (sx < sy) ? 1 : 0;
            default: e.r = '0;
        endcase
        e.z = (e.r == 0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Called in the phase just after a rising edge; returns in the same phase after the accept.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int k = 0;
        while (!in_ready && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            check("issue_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        sb.push_back(ref_model(o, x, y, cyc));
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: latency on rising out_valid, hold stability, in_ready exclusion, result on handshake.
    bit           prev_valid = 1'b0;
    bit           prev_hs    = 1'b0;
    logic [W-1:0] prev_r;
    logic [3:0]   prev_f;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_valid", out_valid, 0);
                else check("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
            end
            if (out_valid && prev_valid && !prev_hs) begin
                check("hold_r", r, prev_r);
                check("hold_flags", {z, n, c, v}, prev_f);
            end
            if (prev_hs) check("ready_after_hs", in_ready, 1);
            if (sb.size() != 0) check("busy_in_ready", in_ready, 0);
            if (out_valid && out_ready && sb.size() != 0) begin
                check("result_r", r, sb[0].r);
                check("flags_zncv", {z, n, c, v}, {sb[0].z, sb[0].n, sb[0].c, sb[0].v});
                void'(sb.pop_front());
            end
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid;
            prev_r     = r;
            prev_f     = {z, n, c, v};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_r", r, 0);
        check("reset_flags", {z, n, c, v}, 0);
        @(posedge clk); #1;

        // Directed corner cases with out_ready held high.
        issue(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_SUB,  32'h8000_0000, 32'h0000_0001);
        issue(OP_SUB,  32'h0000_0001, 32'h0000_0002);
        issue(OP_MUL,  32'h0001_0000, 32'h0001_0000);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_NOP,  32'h1234_5678, 32'h9ABC_DEF0);
        wait_drain();

        // Result held while the consumer stalls.
        hold_low = 1'b1;
        issue(OP_OR, 32'h0000_00F0, 32'h0000_000F);
        repeat (5) begin @(posedge clk); #1; end
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_r", r, 32'hFF);
        hold_low = 1'b0;
        wait_drain();

        // Reset ten cycles into a multiply aborts it.
        issue(OP_MUL, $urandom, $urandom);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_r", r, 0);
        check("abort_flags", {z, n, c, v}, 0);
        repeat (40) @(posedge clk);
        #1;

        // Randomized traffic with a randomly stalling consumer.
        force_high = 1'b0;
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
